muldiv_ctrl: RTL
================

Name: muldiv_ctrl

Overview:
- Sequencer for the HI/LO multiply/divide resource. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and runs a multi-cycle multiply or a radix-2 restoring divide. Owns the architectural HI/LO registers.
- Raises md_busy, which the pipeline control unit ORs into its EX-hold condition. EX keeps the operation in place until the result is committed.

Parameters:
MUL_CYCLES, 2, number of stall cycles for MULT/MULTU (legal 1..4)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ex_valid  in  1  EX holds a valid, non-flushed instruction
ex_op  in  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none)
ex_a  in  32  rs operand after forwarding (dividend / multiplicand / MTHI-MTLO data)
ex_b  in  32  rt operand after forwarding (divisor / multiplier)
exc_oc  in  1  exception/flush; same signal that refreshes the pipeline registers
md_busy  out  1  hold EX (combinational)
md_done  out  1  one-cycle pulse on the cycle HI/LO commit from a MUL/DIV
hi  out  32  HI register
lo  out  32  LO register
md_state  out  2  current state, for debug

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0, hi=lo=0, md_busy=0, md_done=0.
- start = ex_valid & !exc_oc & state==IDLE & ex_op in {1..4}.
- States are IDLE=0, MUL=1, DIV=2, FIX=3.
- IDLE, start: md_busy=1. Operands are latched at the edge.
  - MULT/MULTU go to MUL with cnt=MUL_CYCLES-1.
  - DIV/DIVU go to DIV with cnt=31.
  - Signed ops latch operand magnitudes plus quotient sign (a^b) and remainder sign (a).
- MUL: the product is 64-bit, signed or unsigned per op.
  - cnt!=0: md_busy=1, cnt decrements.
  - cnt==0: md_busy=0, md_done=1, {hi,lo}=product at the edge, then go to IDLE.
  - EX stall = MUL_CYCLES cycles.
- DIV: one restoring iteration per cycle, md_busy=1.
  - At cnt==0, perform the last iteration and go to FIX.
- FIX: apply sign fix (quotient negated if a^b, remainder negated if a<0). md_busy=0, md_done=1.
  - lo=quotient, hi=remainder at the edge, then go to IDLE.
  - DIV/DIVU EX stall = 33 cycles.
- FIX/MUL->IDLE coincides with EX advancing. The same instruction is never restarted.
- MTHI/MTLO in IDLE with ex_valid & !exc_oc: hi (or lo) = ex_a at the edge. No stall, md_done=0.
- MTHI/MTLO cannot reach EX while busy, because EX is held.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero: the result is forced to lo=0xFFFFFFFF, hi=ex_a, for both DIV and DIVU. Timing is per the Optional Feature section.
- Flush: exc_oc=1 in any state forces md_busy=0 and suppresses start and MTHI/MTLO writes.
  - Next state is IDLE, cnt=0, hi/lo unchanged, md_done=0.
  - exc_oc overrides a MUL/FIX commit in the same cycle.
- md_busy is combinational from state, cnt, start and exc_oc only. There is no path from hi/lo.
- Reset mid-operation: immediate IDLE, hi=lo=0.

Optional Feature:
- Macro MD_DIVZ_FAST_EN.
- Defined: DIV/DIVU with ex_b==0 in IDLE does not enter DIV. lo=0xFFFFFFFF and hi=ex_a are written at the accept edge. md_busy=0, md_done=1 that cycle, zero stall.
- Undefined: the divide runs the full 32 iterations plus FIX (33-cycle stall). FIX forces the same result values.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, MUL_CYCLES=2 -> md_busy high 2 cycles; hi=0xFFFFFFFE, lo=0x00000001; md_done pulses once.
- MULT a=0xFFFFFFFE b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7) b=2 -> 33 busy cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=7 -> lo=14, hi=2. Also DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234 b=0 -> lo=0xFFFFFFFF, hi=0x1234. Stall is 0 cycles with MD_DIVZ_FAST_EN, 33 without.
- DIV started, exc_oc at iteration 10 -> md_busy=0 that cycle, state IDLE next, hi/lo keep prior values; then MTHI 0xA5A5A5A5 -> hi=0xA5A5A5A5 with no stall. rst asserted mid-MUL -> hi=lo=0, md_busy=0 immediately.

Source files
------------

// File: rtl/muldiv_ctrl_if.sv
// EX-stage to HI/LO multiply/divide sequencer interface.
// master = EX stage / pipeline control, slave = muldiv_ctrl.
interface muldiv_ctrl_if;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic        exc_oc;
  logic        md_busy;
  logic        md_done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  md_state;

  modport master (
    output ex_valid, ex_op, ex_a, ex_b, exc_oc,
    input  md_busy, md_done, hi, lo, md_state
  );

  modport slave (
    input  ex_valid, ex_op, ex_a, ex_b, exc_oc,
    output md_busy, md_done, hi, lo, md_state
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: multi-cycle MULT/MULTU, radix-2 restoring DIV/DIVU, MTHI/MTLO.
// Optional macro MD_DIVZ_FAST_EN: divide-by-zero commits at the accept edge with no stall.
module muldiv_ctrl #(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  muldiv_ctrl_if.slave      bus
);
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  op_a, op_b, quo, rem, hi_q, lo_q;
  logic          op_signed, q_neg, r_neg, div_zero;

  logic          is_mul, is_div, is_signed, go, start, fast_divz, mul_last;
  logic          a_sgn, b_sgn;
  logic [W-1:0]  a_mag, b_mag;
  logic [W:0]    rem_sh, diff;
  logic          take;
  logic [W-1:0]  rem_nx, quo_nx, q_fix, r_fix;
  logic [2*W-1:0] ext_a, ext_b, prod;

  // Decode and accept qualification; reset also blocks a start so md_busy drops at once.
  assign is_mul    = (bus.ex_op == OP_MULT) || (bus.ex_op == OP_MULTU);
  assign is_div    = (bus.ex_op == OP_DIV)  || (bus.ex_op == OP_DIVU);
  assign is_signed = (bus.ex_op == OP_MULT) || (bus.ex_op == OP_DIV);
  assign go        = bus.ex_valid & ~bus.exc_oc & ~rst;
  assign start     = go & (state == IDLE) & (is_mul | is_div);

`ifdef MD_DIVZ_FAST_EN
  assign fast_divz = start & is_div & (bus.ex_b == '0);
`else
  assign fast_divz = 1'b0;
`endif

  assign mul_last    = (state == MUL) && (cnt == '0);
  assign bus.md_busy = ~bus.exc_oc & ~rst &
                       ((start & ~fast_divz) | ((state == MUL) && (cnt != '0)) | (state == DIV));
  assign bus.md_done = ~bus.exc_oc & ~rst & (fast_divz | mul_last | (state == FIX));

  // Operand magnitudes for signed divide
  assign a_sgn = (bus.ex_op == OP_DIV) & bus.ex_a[W-1];
  assign b_sgn = (bus.ex_op == OP_DIV) & bus.ex_b[W-1];
  assign a_mag = a_sgn ? -bus.ex_a : bus.ex_a;
  assign b_mag = b_sgn ? -bus.ex_b : bus.ex_b;

  // One restoring step: shift dividend bit into remainder, subtract if it fits
  assign rem_sh = {rem, quo[W-1]};
  assign diff   = rem_sh - {1'b0, op_b};
  assign take   = ~diff[W];
  assign rem_nx = take ? diff[W-1:0] : rem_sh[W-1:0];
  assign quo_nx = {quo[W-2:0], take};

  assign q_fix = q_neg ? -quo : quo;
  assign r_fix = r_neg ? -rem : rem;

  // Sign/zero extension to 64 bits makes one truncated multiply serve both MULT and MULTU
  assign ext_a = {{W{op_signed & op_a[W-1]}}, op_a};
  assign ext_b = {{W{op_signed & op_b[W-1]}}, op_b};
  assign prod  = ext_a * ext_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      quo       <= '0;
      rem       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      op_signed <= 1'b0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      div_zero  <= 1'b0;
    end else if (bus.exc_oc) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fast_divz) begin
            hi_q <= bus.ex_a;
            lo_q <= '1;
          end else if (start) begin
            op_a      <= bus.ex_a;
            op_signed <= is_signed;
            if (is_mul) begin
              state <= MUL;
              cnt   <= CW'(MUL_CYCLES - 1);
              op_b  <= bus.ex_b;
            end else begin
              state    <= DIV;
              cnt      <= CW'(31);
              op_b     <= b_mag;
              quo      <= a_mag;
              rem      <= '0;
              q_neg    <= a_sgn ^ b_sgn;
              r_neg    <= a_sgn;
              div_zero <= (bus.ex_b == '0);
            end
          end else if (go && bus.ex_op == OP_MTHI) begin
            hi_q <= bus.ex_a;
          end else if (go && bus.ex_op == OP_MTLO) begin
            lo_q <= bus.ex_a;
          end
        end
        MUL: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            {hi_q, lo_q} <= prod;
            state        <= IDLE;
          end
        end
        DIV: begin
          rem <= rem_nx;
          quo <= quo_nx;
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - CW'(1);
        end
        FIX: begin
          if (div_zero) begin
            hi_q <= op_a;
            lo_q <= '1;
          end else begin
            hi_q <= r_fix;
            lo_q <= q_fix;
          end
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.md_state = state;
endmodule
